// File: rtl/v_vram_arbiter_if.sv
// One requester port of the VRAM arbiter: request handshake plus 1-cycle read response.
// master = requester side, slave = arbiter side.
interface v_vram_arbiter_if #(
    parameter int unsigned Aw = 64,
    parameter int unsigned Dw = 512
);
    logic          valid;
    logic          ready;
    logic          we;
    logic          lock;
    logic [Aw-1:0] addr;
    logic [Dw-1:0] wdata;
    logic [Dw-1:0] wmask;
    logic          rsp_valid;
    logic [Dw-1:0] rsp_rdata;

    modport master (
        output valid, we, lock, addr, wdata, wmask,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, we, lock, addr, wdata, wmask,
        output ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/v_vram_arbiter.sv
// Two-port round-robin VRAM arbiter with burst lock, starvation-driven lock break and
// 1-cycle read response routing back to the issuing port.
module v_vram_arbiter #(
    parameter int unsigned VramAw  = 64,
    parameter int unsigned VramDw  = 512,
    parameter int unsigned MaxWait = 8
) (
    input  logic              clk,
    input  logic              rst,
    v_vram_arbiter_if.slave   req0_if,
    v_vram_arbiter_if.slave   req1_if,
    output logic              vram_r_ena_o,
    output logic [VramAw-1:0] vram_r_addr_o,
    input  logic [VramDw-1:0] vram_r_data_i,
    output logic              vram_w_ena_o,
    output logic [VramAw-1:0] vram_w_addr_o,
    output logic [VramDw-1:0] vram_w_data_o,
    output logic [VramDw-1:0] vram_w_mask_o
);
    localparam int unsigned    WaitW   = $clog2(MaxWait + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic [WaitW-1:0] wait0_q, wait0_d, wait1_q, wait1_d;
    logic             rsp_pend_q, rsp_pend_d;
    logic             rsp_id_q, rsp_id_d;

    logic v0, v1, starve0, starve1, gnt0, gnt1, acc, acc_we;

    // Reset gates the valids so nothing is accepted or driven while rst is low.
    assign v0      = req0_if.valid & rst;
    assign v1      = req1_if.valid & rst;
    assign starve0 = v0 & (wait0_q >= WaitMax);
    assign starve1 = v1 & (wait1_q >= WaitMax);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            StOwn0: begin
                if (starve1)  gnt1 = 1'b1;
                else if (v0)  gnt0 = 1'b1;
                else if (v1)  gnt1 = 1'b1;
            end
            StOwn1: begin
                if (starve0)  gnt0 = 1'b1;
                else if (v1)  gnt1 = 1'b1;
                else if (v0)  gnt0 = 1'b1;
            end
            default: begin
                if (v0 && v1) begin
                    gnt0 = ~rr_q;
                    gnt1 = rr_q;
                end else begin
                    gnt0 = v0;
                    gnt1 = v1;
                end
            end
        endcase
    end

    assign req0_if.ready = gnt0;
    assign req1_if.ready = gnt1;
    assign acc           = gnt0 | gnt1;
    assign acc_we        = gnt1 ? req1_if.we : req0_if.we;

    always_comb begin
        // Only the owner (or an idle grant) may take/keep ownership; a lock break or a
        // grant to the non-owner always returns to idle.
        state_d = StIdle;
        if (gnt0 && req0_if.lock && state_q != StOwn1) state_d = StOwn0;
        if (gnt1 && req1_if.lock && state_q != StOwn0) state_d = StOwn1;

        rr_d = rr_q;
        if (gnt0) rr_d = 1'b1;
        if (gnt1) rr_d = 1'b0;

        wait0_d = '0;
        if (v0 && !gnt0) wait0_d = (wait0_q == WaitMax) ? wait0_q : wait0_q + 1'b1;
        wait1_d = '0;
        if (v1 && !gnt1) wait1_d = (wait1_q == WaitMax) ? wait1_q : wait1_q + 1'b1;

        rsp_pend_d = acc & ~acc_we;
        rsp_id_d   = gnt1;
    end

    always_comb begin
        vram_r_ena_o  = 1'b0;
        vram_r_addr_o = '0;
        vram_w_ena_o  = 1'b0;
        vram_w_addr_o = '0;
        vram_w_data_o = '0;
        vram_w_mask_o = '0;
        if (acc && !acc_we) begin
            vram_r_ena_o  = 1'b1;
            vram_r_addr_o = gnt1 ? req1_if.addr : req0_if.addr;
        end else if (acc) begin
            vram_w_ena_o  = 1'b1;
            vram_w_addr_o = gnt1 ? req1_if.addr  : req0_if.addr;
            vram_w_data_o = gnt1 ? req1_if.wdata : req0_if.wdata;
            vram_w_mask_o = gnt1 ? req1_if.wmask : req0_if.wmask;
        end
    end

    // Gated by rst so a pending read is suppressed as soon as reset asserts.
    assign req0_if.rsp_valid = rst & rsp_pend_q & ~rsp_id_q;
    assign req1_if.rsp_valid = rst & rsp_pend_q & rsp_id_q;
    assign req0_if.rsp_rdata = req0_if.rsp_valid ? vram_r_data_i : '0;
    assign req1_if.rsp_rdata = req1_if.rsp_valid ? vram_r_data_i : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            wait0_q    <= '0;
            wait1_q    <= '0;
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            wait0_q    <= wait0_d;
            wait1_q    <= wait1_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_id_q   <= rsp_id_d;
        end
    end
endmodule

// File: tb/tb_v_vram_arbiter.sv
// Directed bench for v_vram_arbiter: reset, read response, round-robin, burst lock,
// starvation lock break and reset during a pending read.
module tb_v_vram_arbiter;
    logic         clk;
    logic         rst;
    logic         vram_r_ena;
    logic [63:0]  vram_r_addr;
    logic [511:0] vram_r_data;
    logic         vram_w_ena;
    logic [63:0]  vram_w_addr;
    logic [511:0] vram_w_data;
    logic [511:0] vram_w_mask;

    int n_cmp = 0;
    int n_bad = 0;

    v_vram_arbiter_if #(.Aw(64), .Dw(512)) p0 ();
    v_vram_arbiter_if #(.Aw(64), .Dw(512)) p1 ();

    v_vram_arbiter #(.VramAw(64), .VramDw(512), .MaxWait(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_if       (p0),
        .req1_if       (p1),
        .vram_r_ena_o  (vram_r_ena),
        .vram_r_addr_o (vram_r_addr),
        .vram_r_data_i (vram_r_data),
        .vram_w_ena_o  (vram_w_ena),
        .vram_w_addr_o (vram_w_addr),
        .vram_w_data_o (vram_w_data),
        .vram_w_mask_o (vram_w_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM stand-in: 0x40 holds the A5 pattern, every other address returns itself x8.
    initial vram_r_data = '0;
    always @(posedge clk) begin
        if (vram_r_ena) begin
            if (vram_r_addr == 64'h40) vram_r_data <= {64{8'hA5}};
            else                       vram_r_data <= {8{vram_r_addr}};
        end
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv0(input logic v, input logic we, input logic lk, input logic [63:0] a);
        p0.valid = v;
        p0.we    = we;
        p0.lock  = lk;
        p0.addr  = a;
        p0.wdata = {8{~a}};
        p0.wmask = {8{a}};
    endtask

    task automatic drv1(input logic v, input logic we, input logic lk, input logic [63:0] a);
        p1.valid = v;
        p1.we    = we;
        p1.lock  = lk;
        p1.addr  = a;
        p1.wdata = {8{~a}};
        p1.wmask = {8{a}};
    endtask

    initial begin
        rst = 1'b0;
        drv0(1'b1, 1'b0, 1'b0, 64'h40);
        drv1(1'b1, 1'b0, 1'b0, 64'h80);

        // Reset held with both ports requesting.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_ready0", p0.ready, 1'b0);
            chk("rst_ready1", p1.ready, 1'b0);
            chk("rst_r_ena", vram_r_ena, 1'b0);
            chk("rst_w_ena", vram_w_ena, 1'b0);
            chk("rst_r_addr", vram_r_addr, 64'h0);
            chk("rst_rsp0", p0.rsp_valid, 1'b0);
            chk("rst_rsp1", p1.rsp_valid, 1'b0);
        end

        // Release: port 0 first, read 0x40.
        @(negedge clk); rst = 1'b1; #1;
        chk("rel_ready0", p0.ready, 1'b1);
        chk("rel_ready1", p1.ready, 1'b0);
        chk("rd_r_ena", vram_r_ena, 1'b1);
        chk("rd_r_addr", vram_r_addr, 64'h40);
        chk("rd_w_ena", vram_w_ena, 1'b0);

        @(negedge clk); drv0(1'b0, 1'b0, 1'b0, 64'h0); #1;
        chk("rsp0_valid", p0.rsp_valid, 1'b1);
        chk("rsp0_rdata", p0.rsp_rdata, {64{8'hA5}});
        chk("rsp1_idle", p1.rsp_valid, 1'b0);
        chk("rsp1_rdata0", p1.rsp_rdata, 512'h0);
        chk("p1_ready", p1.ready, 1'b1);
        chk("p1_r_addr", vram_r_addr, 64'h80);

        @(negedge clk); drv1(1'b0, 1'b0, 1'b0, 64'h0); #1;
        chk("rsp1_valid", p1.rsp_valid, 1'b1);
        chk("rsp1_rdata", p1.rsp_rdata, {8{64'h80}});
        chk("rsp0_once", p0.rsp_valid, 1'b0);
        chk("idle_r_ena", vram_r_ena, 1'b0);

        // Contention, unlocked: grants alternate starting at port 0.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                drv0(1'b1, 1'b0, 1'b0, 64'h200);
                drv1(1'b1, 1'b0, 1'b0, 64'h300);
            end
            #1;
            chk("rr_ready0", p0.ready, (i % 2) == 0);
            chk("rr_ready1", p1.ready, (i % 2) == 1);
            chk("rr_addr", vram_r_addr, ((i % 2) == 0) ? 64'h200 : 64'h300);
            if (i > 0) chk("rr_rsp0", p0.rsp_valid, (i % 2) == 1);
        end
        @(negedge clk);
        drv0(1'b0, 1'b0, 1'b0, 64'h0);
        drv1(1'b0, 1'b0, 1'b0, 64'h0);
        #1;
        chk("rr_last_rsp1", p1.rsp_valid, 1'b1);
        chk("rr_last_rdata", p1.rsp_rdata, {8{64'h300}});

        // Single write by port 0 moves the round-robin pointer to port 1.
        @(negedge clk); drv0(1'b1, 1'b1, 1'b0, 64'h100); #1;
        chk("wr_ready0", p0.ready, 1'b1);
        chk("wr_w_ena", vram_w_ena, 1'b1);
        chk("wr_r_ena", vram_r_ena, 1'b0);
        chk("wr_w_addr", vram_w_addr, 64'h100);
        chk("wr_w_data", vram_w_data, {8{~64'h100}});
        chk("wr_w_mask", vram_w_mask, {8{64'h100}});

        // Port 1 burst of 4 locked writes while port 0 keeps requesting.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) drv0(1'b1, 1'b0, 1'b0, 64'h500);
            drv1(1'b1, 1'b1, i < 3, 64'h600 + 64'(i * 16));
            #1;
            chk("lk_ready1", p1.ready, 1'b1);
            chk("lk_ready0", p0.ready, 1'b0);
            chk("lk_w_addr", vram_w_addr, 64'h600 + 64'(i * 16));
            if (i == 0) chk("wr_no_rsp", p0.rsp_valid, 1'b0);
        end
        @(negedge clk); drv1(1'b0, 1'b0, 1'b0, 64'h0); #1;
        chk("lk_after_ready0", p0.ready, 1'b1);
        chk("lk_after_addr", vram_r_addr, 64'h500);

        // Permanent lock by port 1: port 0 breaks through on its 9th waiting cycle.
        @(negedge clk);
        drv0(1'b0, 1'b0, 1'b0, 64'h0);
        drv1(1'b1, 1'b1, 1'b1, 64'h700);
        #1;
        chk("sv_own1", p1.ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) drv0(1'b1, 1'b0, 1'b0, 64'h800);
            #1;
            chk("sv_wait0", p0.ready, 1'b0);
            chk("sv_hold1", p1.ready, 1'b1);
        end
        @(negedge clk); #1;
        chk("sv_break0", p0.ready, 1'b1);
        chk("sv_break1", p1.ready, 1'b0);
        chk("sv_addr", vram_r_addr, 64'h800);
        @(negedge clk); drv0(1'b0, 1'b0, 1'b0, 64'h0); #1;
        chk("sv_rsp0", p0.rsp_valid, 1'b1);
        chk("sv_rdata", p0.rsp_rdata, {8{64'h800}});
        chk("sv_back1", p1.ready, 1'b1);
        @(negedge clk); drv1(1'b0, 1'b0, 1'b0, 64'h0); #1;
        chk("sv_quiet_w", vram_w_ena, 1'b0);

        // Reset arriving one cycle after a read is accepted drops the response.
        @(negedge clk); drv0(1'b1, 1'b0, 1'b0, 64'h40); #1;
        chk("rm_accept", p0.ready, 1'b1);
        @(negedge clk); rst = 1'b0; drv0(1'b0, 1'b0, 1'b0, 64'h0); #1;
        chk("rm_rsp_in_rst", p0.rsp_valid, 1'b0);
        chk("rm_rdata_in_rst", p0.rsp_rdata, 512'h0);
        @(negedge clk); #1;
        chk("rm_rsp_rst2", p0.rsp_valid, 1'b0);
        @(negedge clk); rst = 1'b1; #1;
        chk("rm_rsp_rel", p0.rsp_valid, 1'b0);
        @(negedge clk); #1;
        chk("rm_rsp_rel2", p0.rsp_valid, 1'b0);
        chk("rm_rsp1_rel2", p1.rsp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
